// File: rtl/bcd_to_binary_pkg.sv
// bcd_to_binary_pkg
// Shared constants for the decimal datapaths: digit width, the largest legal
// BCD digit, and the state encoding of the BCD-to-binary converter.
package bcd_to_binary_pkg;

    localparam int         BCD_DIGIT_W   = 4;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } bcd_state_e;

endpackage : bcd_to_binary_pkg

// File: rtl/bcd_to_binary_if.sv
// bcd_to_binary_if
// Start/busy/done handshake and data bus of the BCD-to-binary converter.
//   in_start   : conversion request, only honoured while the converter is idle
//   in_bcd     : packed BCD digits, most significant digit in the top nibble
//   out_busy   : conversion in progress
//   out_done   : one-cycle pulse, results valid from this cycle on
//   out_binary : converted value, held until the next done
//   out_error  : at least one input digit was above 9, held with out_binary
// master drives the request side, slave is the converter.
interface bcd_to_binary_if
    import bcd_to_binary_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
);
    logic                          in_start;
    logic [BCD_DIGIT_W*DIGITS-1:0] in_bcd;
    logic                          out_busy;
    logic                          out_done;
    logic [BIN_W-1:0]              out_binary;
    logic                          out_error;

    modport master (
        output in_start,
        output in_bcd,
        input  out_busy,
        input  out_done,
        input  out_binary,
        input  out_error
    );

    modport slave (
        input  in_start,
        input  in_bcd,
        output out_busy,
        output out_done,
        output out_binary,
        output out_error
    );
endinterface : bcd_to_binary_if

// File: rtl/bcd_to_binary_digit_mac.sv
// bcd_digit_mac
// Combinational decimal multiply-accumulate step: acc_o = acc_i*10 + digit_i,
// truncated to BIN_W bits, plus a flag for a digit outside 0..9.
//   acc_i           : running binary accumulator
//   digit_i         : next BCD digit
//   acc_o           : acc_i*10 + digit_i, low BIN_W bits
//   digit_invalid_o : digit_i > 9
module bcd_digit_mac
    import bcd_to_binary_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic [BIN_W-1:0]       acc_i,
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BIN_W-1:0]       acc_o,
    output logic                   digit_invalid_o
);

    // Only the low BIN_W bits of the product are kept, so the sum is formed
    // directly at BIN_W; modular addition gives the same low bits as a wider
    // sum truncated afterwards.
    always_comb begin
        acc_o           = (acc_i << 3) + (acc_i << 1) + BIN_W'(digit_i);
        digit_invalid_o = (digit_i > BCD_MAX_DIGIT);
    end

endmodule : bcd_digit_mac

// File: rtl/bcd_to_binary.sv
// bcd_to_binary
// Sequential packed-BCD to binary converter, one digit per clock, most
// significant digit first (acc = acc*10 + digit). Fixed latency: the done
// pulse follows DIGITS convert cycles; invalid digits never shorten it.
//   in_clk   : system clock, rising edge
//   in_rst_n : asynchronous active-low reset
//   bus      : slave side of bcd_to_binary_if (start/bcd in, busy/done/
//              binary/error out)
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | waiting for in_start; outputs hold the last result
//   ST_CONVERT | folding one digit per cycle into the accumulator
//   ST_DONE    | single cycle, out_done high, results already registered
module bcd_to_binary
    import bcd_to_binary_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    bcd_to_binary_if.slave   bus
);

    localparam int SR_W  = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    bcd_state_e              state_q, state_d;
    logic [SR_W-1:0]         sr_q, sr_d;
    logic [BIN_W-1:0]        acc_q, acc_d;
    logic                    err_q, err_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BIN_W-1:0]        bin_q, bin_d;
    logic                    oerr_q, oerr_d;

    logic [BCD_DIGIT_W-1:0]  top_digit;
    logic [BIN_W-1:0]        mac_acc;
    logic                    mac_invalid;

    assign top_digit = sr_q[SR_W-1 -: BCD_DIGIT_W];

    bcd_digit_mac #(
        .BIN_W (BIN_W)
    ) u_mac (
        .acc_i           (acc_q),
        .digit_i         (top_digit),
        .acc_o           (mac_acc),
        .digit_invalid_o (mac_invalid)
    );

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            bin_q   <= '0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            oerr_q  <= oerr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        oerr_d  = oerr_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_start) begin
                    sr_d    = bus.in_bcd;
                    acc_d   = '0;
                    err_d   = 1'b0;
                    cnt_d   = CNT_W'(DIGITS - 1);
                    state_d = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                acc_d = mac_acc;
                err_d = err_q | mac_invalid;
                sr_d  = sr_q << BCD_DIGIT_W;
                if (cnt_q == '0) begin
                    // Result registers load on the last digit so they are
                    // valid in the same cycle as out_done.
                    state_d = ST_DONE;
                    bin_d   = err_d ? '0 : mac_acc;
                    oerr_d  = err_d;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.out_busy   = (state_q != ST_IDLE);
    assign bus.out_done   = (state_q == ST_DONE);
    assign bus.out_binary = bin_q;
    assign bus.out_error  = oerr_q;

endmodule : bcd_to_binary

// File: tb/tb_bcd_to_binary.sv
module tb_bcd_to_binary;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    logic [31:0] prev_bin;
    logic        prev_err;

    int          n_done;
    int          done_cyc [3];
    logic [31:0] done_val [3];
    logic [31:0] cap_val;

    bcd_to_binary_if #(.DIGITS(4), .BIN_W(14)) bus ();

    bcd_to_binary #(
        .DIGITS (4),
        .BIN_W  (14)
    ) dut (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Start a conversion, then walk cycle by cycle through CONVERT/DONE/IDLE.
    // in_bcd is scrambled right after acceptance; the result must not care.
    task automatic run_conv(input string name, input logic [15:0] bcd,
                            input logic [31:0] exp_bin, input logic exp_err);
        @(negedge clk);
        bus.in_start = 1'b1;
        bus.in_bcd   = bcd;
        @(negedge clk);
        bus.in_start = 1'b0;
        bus.in_bcd   = 16'hFFFF;
        chk({name, " busy c0"}, 32'(bus.out_busy), 32'd1);
        chk({name, " done c0"}, 32'(bus.out_done), 32'd0);
        chk({name, " hold bin c0"}, 32'(bus.out_binary), prev_bin);
        chk({name, " hold err c0"}, 32'(bus.out_error), 32'(prev_err));
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk({name, " busy"}, 32'(bus.out_busy), 32'd1);
            if (i < 4) begin
                chk({name, " early done"}, 32'(bus.out_done), 32'd0);
            end else begin
                chk({name, " done"}, 32'(bus.out_done), 32'd1);
                chk({name, " binary"}, 32'(bus.out_binary), exp_bin);
                chk({name, " error"}, 32'(bus.out_error), 32'(exp_err));
            end
        end
        @(negedge clk);
        chk({name, " idle busy"}, 32'(bus.out_busy), 32'd0);
        chk({name, " idle done"}, 32'(bus.out_done), 32'd0);
        chk({name, " idle bin"}, 32'(bus.out_binary), exp_bin);
        prev_bin = exp_bin;
        prev_err = exp_err;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_start = 1'b0;
        bus.in_bcd   = 16'h0000;
        prev_bin     = 32'd0;
        prev_err     = 1'b0;

        #3;
        chk("reset busy", 32'(bus.out_busy), 32'd0);
        chk("reset done", 32'(bus.out_done), 32'd0);
        chk("reset binary", 32'(bus.out_binary), 32'd0);
        chk("reset error", 32'(bus.out_error), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle after reset busy", 32'(bus.out_busy), 32'd0);

        run_conv("c1234", 16'h1234, 32'd1234, 1'b0);
        run_conv("c9999", 16'h9999, 32'd9999, 1'b0);
        run_conv("c0000", 16'h0000, 32'd0,    1'b0);
        run_conv("c12A4", 16'h12A4, 32'd0,    1'b1);
        run_conv("c0042", 16'h0042, 32'd42,   1'b0);
        run_conv("cF000", 16'hF000, 32'd0,    1'b1);
        run_conv("c0009", 16'h0009, 32'd9,    1'b0);

        // Start and data changes during CONVERT must be ignored.
        @(negedge clk);
        bus.in_start = 1'b1;
        bus.in_bcd   = 16'h0357;
        @(negedge clk);
        bus.in_bcd   = 16'h9999;
        n_done  = 0;
        cap_val = 32'd0;
        done_cyc[0] = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 2) begin
                bus.in_start = 1'b0;
                bus.in_bcd   = 16'h8888;
            end
            if (bus.out_done === 1'b1) begin
                if (n_done == 0) begin
                    done_cyc[0] = c;
                    cap_val     = 32'(bus.out_binary);
                end
                n_done++;
            end
        end
        chk("ignore start done count", 32'(n_done), 32'd1);
        chk("ignore start done cycle", 32'(done_cyc[0]), 32'd4);
        chk("ignore start value", cap_val, 32'd357);
        prev_bin = 32'd357;

        // Asynchronous reset in the second CONVERT cycle.
        @(negedge clk);
        bus.in_start = 1'b1;
        bus.in_bcd   = 16'h0888;
        @(negedge clk);
        bus.in_start = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst busy", 32'(bus.out_busy), 32'd0);
        chk("async rst done", 32'(bus.out_done), 32'd0);
        chk("async rst binary", 32'(bus.out_binary), 32'd0);
        chk("async rst error", 32'(bus.out_error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.out_done === 1'b1) n_done++;
        end
        chk("no done after reset", 32'(n_done), 32'd0);
        prev_bin = 32'd0;
        prev_err = 1'b0;
        run_conv("c0507", 16'h0507, 32'd507, 1'b0);

        // in_start held high for three back-to-back conversions.
        @(negedge clk);
        bus.in_start = 1'b1;
        bus.in_bcd   = 16'h0001;
        n_done = 0;
        for (int k = 0; k < 3; k++) begin
            done_cyc[k] = -1;
            done_val[k] = 32'hFFFF_FFFF;
        end
        for (int c = 0; c <= 22; c++) begin
            @(negedge clk);
            if (c == 1)  bus.in_bcd = 16'h0010;
            if (c == 7)  bus.in_bcd = 16'h0100;
            if (c == 13) bus.in_start = 1'b0;
            if (bus.out_done === 1'b1) begin
                if (n_done < 3) begin
                    done_cyc[n_done] = c;
                    done_val[n_done] = 32'(bus.out_binary);
                end
                n_done++;
            end
        end
        chk("held start done count", 32'(n_done), 32'd3);
        chk("held start done0 cycle", 32'(done_cyc[0]), 32'd4);
        chk("held start done1 cycle", 32'(done_cyc[1]), 32'd10);
        chk("held start done2 cycle", 32'(done_cyc[2]), 32'd16);
        chk("held start value0", done_val[0], 32'd1);
        chk("held start value1", done_val[1], 32'd10);
        chk("held start value2", done_val[2], 32'd100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bcd_to_binary
